// File: rtl/apb_pkg.sv
// apb_pkg: shared types and bus widths for the APB requester and its benches
package apb_pkg;
    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;
endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command/response port plus APB bus signals of the requester
interface apb_master_if import apb_pkg::*; #(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
        output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PREADY, PRDATA,
        input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
               PSEL, PENABLE, PADDR, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles with PREADY low and flags the last allowed one
module apb_wait_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] r_cnt;

    assign o_expired = (r_cnt == W'(TIMEOUT - 1));

    // clear on entry to ACCESS, then count stalled cycles, saturating at the limit
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_en && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-command APB requester with wait-state support and stall timeout
module apb_master import apb_pkg::*; #(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 32
) (
    input logic          PCLK,
    input logic          PRESET,
    apb_master_if.master bus
);
    apb_state_t        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic              r_rsp_timeout;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_expired;

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.rsp_rdata   = r_rsp_rdata;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .i_clear   (r_state == SETUP),
        .i_en      (r_state == ACCESS && !bus.PREADY),
        .o_expired (w_expired)
    );

    // IDLE -> SETUP -> ACCESS sequencer; PREADY beats the timeout on the last cycle
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                IDLE: if (bus.req_valid) begin
                    r_paddr   <= bus.req_addr;
                    r_pwdata  <= bus.req_wdata;
                    r_pwrite  <= bus.req_write;
                    r_psel    <= 1'b1;
                    r_penable <= 1'b0;
                    r_state   <= SETUP;
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: if (bus.PREADY || w_expired) begin
                    r_psel        <= 1'b0;
                    r_penable     <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_rsp_timeout <= !bus.PREADY;
                    r_rsp_rdata   <= (bus.PREADY && !r_pwrite) ? bus.PRDATA : '0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
APB requester (initiator) for the 8-bit-address / 32-bit-data APB bus used by the team's APB memory slave.
- Accepts single read/write commands on a valid/ready request port.
- Sequences each command through the APB SETUP and ACCESS phases and waits on PREADY, honouring slave wait states.
- Returns read data or a write acknowledge on a one-cycle response strobe.
- Aborts a transfer with a timeout flag if the slave stalls too long.
- Sits between a test/CPU-side command source and the APB slave ports.

Parameters:
ADDR_W, 8, APB address width (PADDR, req_addr)
DATA_W, 32, APB data width (PWDATA, PRDATA, req_wdata, rsp_rdata)
TIMEOUT, 32, max ACCESS-phase cycles with PREADY low before abort; must be >= 2 and > max slave wait (PWAIT max 15)

Ports:
PCLK  in  1  bus clock; all logic on rising edge
PRESET  in  1  reset, asynchronous, active-high
req_valid  in  1  command present
req_ready  out  1  master can accept a command; high only in IDLE
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle pulse: transfer finished
rsp_rdata  out  DATA_W  captured PRDATA; valid with rsp_valid on reads, 0 on writes and timeouts
rsp_timeout  out  1  qualifies rsp_valid: transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready / wait-state control
PRDATA  in  DATA_W  slave read data

Behaviour:
Reset:
- PRESET high forces IDLE immediately, independent of PCLK.
- PSEL, PENABLE, PWRITE, rsp_valid and rsp_timeout go to 0.
- PADDR, PWDATA and rsp_rdata go to 0.
- The wait counter clears.
- Reset asserted mid-transfer drops PSEL/PENABLE at once. No response is issued for the lost transfer.

State machine (registered outputs; state enum IDLE, SETUP, ACCESS):
- IDLE:
  - req_ready = 1, combinational from state.
  - On an edge with req_valid = 1: latch req_addr into PADDR, req_wdata into PWDATA and req_write into PWRITE; set PSEL = 1, PENABLE = 0; go to SETUP.
  - Otherwise PSEL = PENABLE = 0, and PADDR/PWDATA/PWRITE hold their last values.
- SETUP: always exactly one cycle. Next edge sets PENABLE = 1, clears the wait counter, and goes to ACCESS.
- ACCESS, edge with PREADY = 1:
  - Set PSEL = PENABLE = 0 and rsp_valid = 1, rsp_timeout = 0.
  - rsp_rdata = PRDATA if PWRITE = 0, else 0.
  - Go to IDLE.
- ACCESS, edge with PREADY = 0 and wait counter = TIMEOUT-1:
  - Abort: set PSEL = PENABLE = 0 and rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
  - Go to IDLE.
- ACCESS, edge with PREADY = 0 and counter below TIMEOUT-1: increment the counter and stay in ACCESS, all bus outputs stable.
- On the final timeout cycle PREADY = 1 wins: normal completion, no timeout.

Response and timing:
- rsp_valid and rsp_timeout are high for exactly one cycle, the cycle after completion, and are cleared on every other edge.
- rsp_rdata holds until the next response.
- Latency with command accepted at edge N: SETUP visible N..N+1, ACCESS from N+1. With zero slave waits, completion is sampled at edge N+2, rsp_valid is high in cycle N+2..N+3, and the next command is accepted at N+3 earliest.
  - Minimum 3 cycles per transfer; each wait state adds 1.
- A timeout abort leaves ACCESS exactly TIMEOUT cycles after it was entered.

Protocol rules:
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
- PENABLE is never high without PSEL.
- No back-to-back transfers without passing through IDLE.
- req_valid while not in IDLE is ignored; the requester must hold it until a handshake completes.
- Wait counter width is $clog2(TIMEOUT).

Decomposition:
- Package apb_pkg:
  - apb_state_t enum {IDLE, SETUP, ACCESS}.
  - APB_ADDR_W = 8, APB_DATA_W = 32 constants.
  - Request struct apb_req_t {write, addr, wdata} shared with the slave-side bench.
- One natural sub-module, apb_wait_timer:
  - Inputs: clear, count-enable.
  - Output: expired flag at TIMEOUT-1.
  - Reset by PRESET.
- Everything else stays in apb_master.

Test Plan:
- Write req_addr 0x10, req_wdata 0xDEADBEEF, slave PWAIT 0 -> PSEL=1/PENABLE=0 one cycle, PENABLE=1 one cycle with PADDR 0x10, PWDATA 0xDEADBEEF, PWRITE 1; rsp_valid 1 for one cycle, rsp_rdata 0, rsp_timeout 0; memory[0x10] = 0xDEADBEEF.
- Read 0x10 after that write, PWAIT 0 -> rsp_rdata 0xDEADBEEF, rsp_valid 3 cycles after accept, PWRITE 0 throughout.
- Read 0x20 with PWAIT 5 -> ACCESS lasts 6 cycles, PADDR/PENABLE stable throughout, response 8 cycles after accept with correct data.
- PREADY tied 0, TIMEOUT 32 -> ACCESS exactly 32 cycles, then PSEL=PENABLE=0; rsp_valid 1 with rsp_timeout 1 and rsp_rdata 0; req_ready high the next cycle.
- PRESET pulsed during ACCESS of a write to 0x30 -> PSEL/PENABLE 0 before the next PCLK edge, no rsp_valid, state IDLE; a new read of 0x10 afterwards completes normally.
- req_valid held high with 4 queued writes to 0x00..0x03 -> exactly 4 handshakes, each in IDLE, 3 cycles apart at PWAIT 0; 4 rsp_valid pulses; no PSEL gap shorter than one IDLE cycle.
